keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Drives the 5x4 calculator keypad matrix one row at a time, samples the
//  active-low columns, and debounces every press and release. A stable
//  single-key press is reported as a one-hot row code plus a raw active-low
//  column pattern, the pair GetAddress decodes to a 4-bit key address.
//  Sits between the board keypad pins and GetAddress/calculator control.
// PARAMETERS
//  SCAN_DIV      50000  clk cycles per row dwell; >=2
//  DEBOUNCE_CNT  4      consecutive identical samples to accept press/release; >=2
// PORTS
//  clk        in   1  system clock, rising edge
//  rst        in   1  asynchronous, active-high reset
//  col_in     in   4  keypad columns, active-low (pull-ups; 1111 = none)
//  row_drv    out  5  keypad row drive, active-low one-cold
//  rowOut     out  5  row of last accepted key, one-hot active-high
//  colOut     out  4  column pattern of last accepted key, active-low
//  key_valid  out  1  1-cycle pulse: new key accepted into rowOut/colOut
//  key_down   out  1  high from key_valid until release is debounced
// BEHAVIOUR
//  Reset (async, immediate from any state):
//   row_drv=11110, rowOut=00000, colOut=1111, key_valid=0, key_down=0,
//   div_cnt=0, row_ptr=0, state=SCAN, dbc=0.
//  Timing:
//   - div_cnt counts 0..SCAN_DIV-1 and wraps.
//   - tick = (div_cnt==SCAN_DIV-1).
//   - col_in is sampled only on tick, at the end of the row dwell.
//   - row_drv = ~(1<<row_ptr), registered.
//   - row_ptr advances 0->1->2->3->4->0, only where stated below.
//  "Single" = col_in has exactly one 0 bit. 0000-1110 patterns with >1 zero
//   (multi-key) are treated exactly as 1111 (no key).
//  State SCAN:
//   - tick & single: cand_col<=col_in, dbc<=1, hold row_ptr, ->DEBOUNCE.
//   - tick otherwise: advance row_ptr.
//  State DEBOUNCE (row_ptr frozen):
//   - tick & col_in==cand_col: dbc++.
//   - Reaching DEBOUNCE_CNT: rowOut<=1<<row_ptr, colOut<=cand_col,
//     key_valid=1 for the next cycle only, key_down<=1, dbc<=0, ->HELD.
//   - tick & mismatch: dbc<=0, advance row_ptr, ->SCAN.
//  State HELD (row_ptr frozen):
//   - tick & col_in==1111: dbc++.
//   - tick & col_in!=1111: dbc<=0 (any pattern, including a new key).
//   - dbc reaching DEBOUNCE_CNT: key_down<=0, advance row_ptr, ->SCAN.
//  rowOut/colOut hold the last key through release and scanning. They change
//   only with key_valid.
//  Latency: key_valid rises 1 clk after the tick of the DEBOUNCE_CNT-th
//   matching sample. Exactly one key_valid per press, however long held.
//  Key change while HELD (slide to another key) is ignored until all keys
//   are released.
//  Widths: div_cnt $clog2(SCAN_DIV); dbc $clog2(DEBOUNCE_CNT+1);
//   row_ptr 3 bits, never exceeds 4.
// TESTING  (SCAN_DIV=4, DEBOUNCE_CNT=3)
//  1 Idle after reset, col_in=1111 -> row_drv steps 11110,11101,11011,
//    10111,01111,11110 every 4 clk; key_valid never asserts.
//  2 col_in=1101 only while row_drv=11101, held -> after 3 matching ticks:
//    one key_valid pulse, rowOut=00010, colOut=1101, key_down=1.
//  3 Same key, but col_in=1111 at 2nd tick (bounce) -> no key_valid;
//    row_drv moves to 11011 after that tick.
//  4 col_in=1001 on row 1 (two keys) -> ignored, scanning continues.
//    Then col_in=1110 on row 3 -> rowOut=01000, colOut=1110.
//  5 Case 2 held 20 ticks -> one key_valid only. Then col_in=1111 for
//    3 ticks -> key_down=0, row_drv=11011, rowOut/colOut unchanged.
//  6 rst pulsed mid-DEBOUNCE, between clock edges -> all outputs at reset
//    values before the next clk edge. Scanning restarts at row 0.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 5x4 keypad matrix one row at a time and debounces both press and
//   release. A stable single-key press is reported as a one-hot row code plus
//   the raw active-low column pattern, which GetAddress turns into a key address.
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst        in   1  asynchronous, active-high reset
//   col_in     in   4  keypad columns, active-low (1111 = no key)
//   row_drv    out  5  keypad row drive, active-low one-cold
//   rowOut     out  5  row of last accepted key, one-hot
//   colOut     out  4  column pattern of last accepted key, active-low
//   key_valid  out  1  one-cycle pulse when a new key is accepted
//   key_down   out  1  high from key_valid until the release is debounced
module keypad_scanner #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_in,
    output logic [4:0] row_drv,
    output logic [4:0] rowOut,
    output logic [3:0] colOut,
    output logic       key_valid,
    output logic       key_down
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DBC_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(DEBOUNCE_CNT - 1);
    localparam logic [DBC_W-1:0] DBC_ONE  = DBC_W'(1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       row_ptr_q, row_ptr_d;
    logic [DBC_W-1:0] dbc_q, dbc_d;
    logic [3:0]       cand_col_q, cand_col_d;
    logic [4:0]       row_drv_q, row_drv_d;
    logic [4:0]       row_out_q, row_out_d;
    logic [3:0]       col_out_q, col_out_d;
    logic             key_valid_q, key_valid_d;
    logic             key_down_q, key_down_d;

    logic             tick;
    logic             single;
    logic [2:0]       next_row;

    assign tick     = (div_cnt_q == DIV_LAST);
    // Multi-key patterns are deliberately not "single", so they behave like no key.
    assign single   = (col_in == 4'b1110) || (col_in == 4'b1101) ||
                      (col_in == 4'b1011) || (col_in == 4'b0111);
    assign next_row = (row_ptr_q == 3'd4) ? 3'd0 : row_ptr_q + 3'd1;

    always_comb begin
        state_d     = state_q;
        div_cnt_d   = tick ? '0 : div_cnt_q + 1'b1;
        row_ptr_d   = row_ptr_q;
        dbc_d       = dbc_q;
        cand_col_d  = cand_col_q;
        row_out_d   = row_out_q;
        col_out_d   = col_out_q;
        key_valid_d = 1'b0;
        key_down_d  = key_down_q;

        case (state_q)
            SCAN: begin
                if (tick) begin
                    if (single) begin
                        cand_col_d = col_in;
                        dbc_d      = DBC_ONE;
                        state_d    = DEBOUNCE;
                    end else begin
                        row_ptr_d = next_row;
                    end
                end
            end
            DEBOUNCE: begin
                if (tick) begin
                    if (col_in == cand_col_q) begin
                        // The sample that reaches the count accepts the key.
                        if (dbc_q == DBC_LAST) begin
                            row_out_d   = 5'b00001 << row_ptr_q;
                            col_out_d   = cand_col_q;
                            key_valid_d = 1'b1;
                            key_down_d  = 1'b1;
                            dbc_d       = '0;
                            state_d     = HELD;
                        end else begin
                            dbc_d = dbc_q + 1'b1;
                        end
                    end else begin
                        dbc_d     = '0;
                        row_ptr_d = next_row;
                        state_d   = SCAN;
                    end
                end
            end
            HELD: begin
                if (tick) begin
                    // Any non-idle pattern, including a different key, restarts the release count.
                    if (col_in == 4'b1111) begin
                        if (dbc_q == DBC_LAST) begin
                            key_down_d = 1'b0;
                            dbc_d      = '0;
                            row_ptr_d  = next_row;
                            state_d    = SCAN;
                        end else begin
                            dbc_d = dbc_q + 1'b1;
                        end
                    end else begin
                        dbc_d = '0;
                    end
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase

        // Registered from the next pointer so row_drv always matches row_ptr.
        row_drv_d = ~(5'b00001 << row_ptr_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SCAN;
            div_cnt_q   <= '0;
            row_ptr_q   <= 3'd0;
            dbc_q       <= '0;
            cand_col_q  <= 4'b1111;
            row_drv_q   <= 5'b11110;
            row_out_q   <= 5'b00000;
            col_out_q   <= 4'b1111;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            row_ptr_q   <= row_ptr_d;
            dbc_q       <= dbc_d;
            cand_col_q  <= cand_col_d;
            row_drv_q   <= row_drv_d;
            row_out_q   <= row_out_d;
            col_out_q   <= col_out_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
        end
    end

    assign row_drv   = row_drv_q;
    assign rowOut    = row_out_q;
    assign colOut    = col_out_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Self-checking bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=3.
//   A table of per-dwell vectors, hand-written press/hold/release and reset
//   sequences, and a randomized phase are all compared against a behavioural
//   key model that works in whole row dwells and sample counts.
module tb_keypad_scanner;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 3;

    logic       clk;
    logic       rst;
    logic [3:0] col_in;
    logic [4:0] row_drv;
    logic [4:0] rowOut;
    logic [3:0] colOut;
    logic       key_valid;
    logic       key_down;

    int checkCount = 0;
    int errorCount = 0;
    int edgeCount  = 0;
    int kvSeen     = 0;

    // Behavioural model: which row is driven, whether a candidate key is being
    // watched, whether a key is held, and how many consistent samples were seen.
    int         mRow;
    bit         mCand;
    bit         mHeld;
    logic [3:0] mCandCol;
    int         mRun;
    int         mRelease;
    logic [4:0] mRowOut;
    logic [3:0] mColOut;
    bit         mKeyValid;
    bit         mKeyDown;

    typedef struct {
        logic [3:0] col;
        logic [4:0] rowDrv;
        logic [4:0] rowOutE;
        logic [3:0] colOutE;
        logic       kv;
        logic       kd;
    } vec_t;

    vec_t vecs[20];

    keypad_scanner #(
        .SCAN_DIV    (SCAN_DIV),
        .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .col_in   (col_in),
        .row_drv  (row_drv),
        .rowOut   (rowOut),
        .colOut   (colOut),
        .key_valid(key_valid),
        .key_down (key_down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int zeroCount(input logic [3:0] v);
        int n = 0;
        for (int i = 0; i < 4; i++) if (v[i] == 1'b0) n++;
        return n;
    endfunction

    task automatic modelReset();
        mRow      = 0;
        mCand     = 0;
        mHeld     = 0;
        mCandCol  = 4'b1111;
        mRun      = 0;
        mRelease  = 0;
        mRowOut   = 5'b00000;
        mColOut   = 4'b1111;
        mKeyValid = 0;
        mKeyDown  = 0;
        edgeCount = 0;
    endtask

    task automatic modelEdge(input logic [3:0] c, input bit tick);
        mKeyValid = 0;
        if (tick) begin
            if (mHeld) begin
                if (c == 4'b1111) begin
                    mRelease++;
                    if (mRelease == DEBOUNCE_CNT) begin
                        mHeld    = 0;
                        mKeyDown = 0;
                        mRelease = 0;
                        mRow     = (mRow + 1) % 5;
                    end
                end else begin
                    mRelease = 0;
                end
            end else if (mCand) begin
                if (c == mCandCol) begin
                    mRun++;
                    if (mRun == DEBOUNCE_CNT) begin
                        mRowOut   = 5'(1 << mRow);
                        mColOut   = mCandCol;
                        mKeyValid = 1;
                        mKeyDown  = 1;
                        mCand     = 0;
                        mHeld     = 1;
                        mRelease  = 0;
                    end
                end else begin
                    mCand = 0;
                    mRow  = (mRow + 1) % 5;
                end
            end else if (zeroCount(c) == 1) begin
                mCand    = 1;
                mCandCol = c;
                mRun     = 1;
            end else begin
                mRow = (mRow + 1) % 5;
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkModel(input string name);
        logic [4:0] expDrv;
        expDrv = ~(5'(1 << mRow));
        checkOutput(name, {16'h0, row_drv, rowOut, colOut, key_valid, key_down},
                    {16'h0, expDrv, mRowOut, mColOut, mKeyValid, mKeyDown});
    endtask

    // One clock: drive at the falling edge, advance the model at the rising
    // edge, compare everything at the next falling edge.
    task automatic applyStimulus(input logic [3:0] c);
        col_in = c;
        @(posedge clk);
        edgeCount++;
        modelEdge(c, (edgeCount % SCAN_DIV) == 0);
        @(negedge clk);
        if (key_valid === 1'b1) kvSeen++;
        checkModel("model");
    endtask

    task automatic runDwell(input logic [3:0] c);
        repeat (SCAN_DIV) applyStimulus(c);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vecs[0]  = '{4'hF, 5'b11101, 5'b00000, 4'b1111, 1'b0, 1'b0};
        vecs[1]  = '{4'hF, 5'b11011, 5'b00000, 4'b1111, 1'b0, 1'b0};
        vecs[2]  = '{4'hF, 5'b10111, 5'b00000, 4'b1111, 1'b0, 1'b0};
        vecs[3]  = '{4'hF, 5'b01111, 5'b00000, 4'b1111, 1'b0, 1'b0};
        vecs[4]  = '{4'hF, 5'b11110, 5'b00000, 4'b1111, 1'b0, 1'b0};
        vecs[5]  = '{4'hF, 5'b11101, 5'b00000, 4'b1111, 1'b0, 1'b0};
        vecs[6]  = '{4'hD, 5'b11101, 5'b00000, 4'b1111, 1'b0, 1'b0};
        vecs[7]  = '{4'hF, 5'b11011, 5'b00000, 4'b1111, 1'b0, 1'b0};
        vecs[8]  = '{4'hF, 5'b10111, 5'b00000, 4'b1111, 1'b0, 1'b0};
        vecs[9]  = '{4'hF, 5'b01111, 5'b00000, 4'b1111, 1'b0, 1'b0};
        vecs[10] = '{4'hF, 5'b11110, 5'b00000, 4'b1111, 1'b0, 1'b0};
        vecs[11] = '{4'hF, 5'b11101, 5'b00000, 4'b1111, 1'b0, 1'b0};
        vecs[12] = '{4'h9, 5'b11011, 5'b00000, 4'b1111, 1'b0, 1'b0};
        vecs[13] = '{4'hF, 5'b10111, 5'b00000, 4'b1111, 1'b0, 1'b0};
        vecs[14] = '{4'hE, 5'b10111, 5'b00000, 4'b1111, 1'b0, 1'b0};
        vecs[15] = '{4'hE, 5'b10111, 5'b00000, 4'b1111, 1'b0, 1'b0};
        vecs[16] = '{4'hE, 5'b10111, 5'b01000, 4'b1110, 1'b1, 1'b1};
        vecs[17] = '{4'hF, 5'b10111, 5'b01000, 4'b1110, 1'b0, 1'b1};
        vecs[18] = '{4'hF, 5'b10111, 5'b01000, 4'b1110, 1'b0, 1'b1};
        vecs[19] = '{4'hF, 5'b01111, 5'b01000, 4'b1110, 1'b0, 1'b0};

        rst    = 1'b0;
        col_in = 4'hF;
        modelReset();
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("reset state", {row_drv, rowOut, colOut, key_valid, key_down},
                    {5'b11110, 5'b00000, 4'b1111, 1'b0, 1'b0});
        @(negedge clk);
        rst = 1'b0;
        modelReset();

        // Idle scanning, bounce, multi-key rejection, press and release on row 3.
        for (int v = 0; v < 20; v++) begin
            for (int k = 0; k < SCAN_DIV - 1; k++) begin
                applyStimulus(vecs[v].col);
                checkOutput("vec key_valid between ticks", {31'h0, key_valid}, 32'h0);
            end
            applyStimulus(vecs[v].col);
            checkOutput($sformatf("vec%0d outputs", v),
                        {row_drv, rowOut, colOut, key_valid, key_down},
                        {vecs[v].rowDrv, vecs[v].rowOutE, vecs[v].colOutE, vecs[v].kv, vecs[v].kd});
        end

        // Press row 1 column 1101, hold it for 20 dwells, then release.
        runDwell(4'hF);
        runDwell(4'hF);
        kvSeen = 0;
        repeat (DEBOUNCE_CNT) runDwell(4'hD);
        checkOutput("press row1 key", {rowOut, colOut, key_down}, {5'b00010, 4'b1101, 1'b1});
        checkOutput("press pulse count", kvSeen, 1);
        repeat (20) runDwell(4'hD);
        checkOutput("long hold pulse count", kvSeen, 1);
        checkOutput("long hold key_down", {31'h0, key_down}, 32'h1);
        repeat (DEBOUNCE_CNT) runDwell(4'hF);
        checkOutput("release outputs", {row_drv, rowOut, colOut, key_down},
                    {5'b11011, 5'b00010, 4'b1101, 1'b0});

        // Reset pulsed between clock edges while a candidate is being debounced.
        runDwell(4'hF);
        runDwell(4'hE);
        applyStimulus(4'hE);
        #2 rst = 1'b1;
        #1;
        checkOutput("async reset mid-debounce", {row_drv, rowOut, colOut, key_valid, key_down},
                    {5'b11110, 5'b00000, 4'b1111, 1'b0, 1'b0});
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        runDwell(4'hF);
        checkOutput("scan restarts at row 0", {27'h0, row_drv}, {27'h0, 5'b11101});

        // Randomized patterns held for a few dwells, with junk between ticks.
        for (int n = 0; n < 300; n++) begin
            logic [3:0] pat;
            int         holdLen;
            if ($urandom_range(0, 2) == 0) pat = 4'hF;
            else pat = 4'hF & ~(4'(1 << $urandom_range(0, 3)));
            holdLen = $urandom_range(1, 6);
            for (int h = 0; h < holdLen; h++) begin
                for (int k = 0; k < SCAN_DIV - 1; k++) begin
                    if ($urandom_range(0, 3) == 0) applyStimulus(4'($urandom));
                    else applyStimulus(pat);
                end
                applyStimulus(pat);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
